mips_fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the MIPS core.
- Replaces the bare PC register (reset/jump/branch/jr mux) with a request/response instruction-memory interface, a prefetch FIFO of DEPTH entries, a redirect/flush path and a halt gate.
- Sits between instruction memory and decode. Decode consumes {inst, inst_pc} through a valid/ready handshake.
- Branch, jump and jr resolution happen downstream and arrive here as redirect_valid/redirect_pc.

---
 rtl/mips_fetch_unit.sv | 83 ++++++++
 tb/tb_mips_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: instruction fetch front end with prefetch FIFO, redirect flush and halt gate
module mips_fetch_unit #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_pc4,
    input  logic            inst_ready,
    output logic [XLEN-1:0] fetch_pc
);
    localparam int AW = $clog2(DEPTH);
    logic [XLEN-1:0] pc, req_pc;
    logic            outstanding, drop;
    logic [XLEN-1:0] fifo_pc [DEPTH];
    logic [31:0]     fifo_inst [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count;
    logic            resp, grant, push, pop;
    always_comb begin
        resp = imem_rvalid && outstanding;
        imem_req = !rst_b && !halt && !redirect_valid && (!outstanding || resp) &&
                   ({1'b0, count} + (AW+2)'(outstanding) < (AW+2)'(DEPTH));
        grant = imem_req && imem_gnt;
        push = resp && !drop && !redirect_valid;
        pop = inst_valid && inst_ready && !redirect_valid;
    end
    assign imem_addr  = pc;
    assign fetch_pc   = pc;
    assign inst_valid = count != '0;
    assign inst       = fifo_inst[rd_ptr];
    assign inst_pc    = fifo_pc[rd_ptr];
    assign inst_pc4   = fifo_pc[rd_ptr] + XLEN'(4);
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= req_pc;
            fifo_inst[wr_ptr] <= imem_rdata;
        end
    end
    always_ff @(posedge clk) begin
        if (rst_b) begin
            pc          <= RESET_PC;
            req_pc      <= RESET_PC;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc & ~XLEN'(3);
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= outstanding && !imem_rvalid;
            drop        <= outstanding && !imem_rvalid;
        end else begin
            if (resp) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end
            if (grant) begin
                outstanding <= 1'b1;
                req_pc      <= pc;
                pc          <= pc + XLEN'(4);
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: scoreboard bench with a queued instruction-memory model
module tb_mips_fetch_unit;
    logic        clk = 0;
    logic        rst_b = 1;
    logic        imem_req, imem_gnt = 1, imem_rvalid = 0;
    logic [31:0] imem_addr, imem_rdata = 0;
    logic        redirect_valid = 0, halt = 1, inst_valid, inst_ready = 1;
    logic [31:0] redirect_pc = 0, inst, inst_pc, inst_pc4, fetch_pc;
    logic        rv_en = 1;
    int          checks = 0, errors = 0, grants = 0, g0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_q[$];
    logic        hold_v = 0;
    logic [31:0] h_inst, h_pc;

    mips_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
        .clk(clk), .rst_b(rst_b), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
        .inst_ready(inst_ready), .fetch_pc(fetch_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        rst_b = 1;
        halt = 1;
        tick(2);
        rst_b = 0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        chk("drain_remaining", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // memory: responds one cycle after grant (when enabled), rdata = addr ^ DEADBEEF
    initial begin
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 0;
            if (rv_en && mem_q.size() != 0) begin
                imem_rvalid = 1;
                imem_rdata = mem_q.pop_front() ^ 32'hDEADBEEF;
            end
            @(negedge clk);
            if (imem_req && imem_gnt) begin
                mem_q.push_back(imem_addr);
                grants++;
            end
        end
    end

    always @(negedge clk) begin
        if (hold_v) begin
            chk("hold_valid", 32'(inst_valid), 1);
            chk("hold_inst", inst, h_inst);
            chk("hold_pc", inst_pc, h_pc);
        end
        hold_v = inst_valid && !inst_ready && !redirect_valid && !rst_b;
        h_inst = inst;
        h_pc = inst_pc;
        if (inst_valid && inst_ready && !redirect_valid && !rst_b) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_inst_pc", inst_pc, 32'hxxxxxxxx);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("inst_pc", inst_pc, e);
                chk("inst", inst, e ^ 32'hDEADBEEF);
                chk("inst_pc4", inst_pc4, e + 32'd4);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        // reset state and zero-wait streaming
        tick(2);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_fetch_pc", fetch_pc, 0);
        tick();
        rst_b = 0; halt = 0;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        @(negedge clk);
        chk("t1_valid_c1", 32'(inst_valid), 0);
        chk("t1_req_c1", 32'(imem_req), 1);
        chk("t1_addr_c1", imem_addr, 0);
        tick();
        @(negedge clk);
        chk("t1_valid_c2", 32'(inst_valid), 0);
        tick();
        @(negedge clk);
        chk("t1_valid_c3", 32'(inst_valid), 1);
        chk("t1_pc_c3", inst_pc, 0);
        tick();
        @(negedge clk);
        chk("t1_pc_c4", inst_pc, 32'h4);
        tick();
        halt = 1;
        @(negedge clk);
        chk("t1_pc_c5", inst_pc, 32'h8);
        chk("t1_halt_req", 32'(imem_req), 0);
        wait_empty();

        // backpressure fills FIFO, then drain and resume
        reset_dut();
        inst_ready = 0; halt = 0; g0 = grants;
        tick(10);
        @(negedge clk);
        chk("t2_grants", grants - g0, 4);
        chk("t2_req_full", 32'(imem_req), 0);
        chk("t2_valid", 32'(inst_valid), 1);
        chk("t2_head", inst_pc, 0);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        tick();
        inst_ready = 1;
        @(negedge clk);
        chk("t2_req_still_full", 32'(imem_req), 0);
        tick();
        @(negedge clk);
        chk("t2_resume_req", 32'(imem_req), 1);
        chk("t2_resume_addr", imem_addr, 32'h10);
        tick();
        halt = 1;
        wait_empty();

        // redirect with request outstanding and two entries buffered
        reset_dut();
        inst_ready = 0; halt = 0;
        tick();
        tick();
        rv_en = 0;
        tick();
        redirect_valid = 1; redirect_pc = 32'h1002; rv_en = 1;
        @(negedge clk);
        chk("t3_req_redir", 32'(imem_req), 0);
        chk("t3_buffered", inst_pc, 0);
        tick();
        redirect_valid = 0; inst_ready = 1;
        exp_q = '{32'h1000};
        @(negedge clk);
        chk("t3_flushed", 32'(inst_valid), 0);
        chk("t3_req", 32'(imem_req), 1);
        chk("t3_addr", imem_addr, 32'h1000);
        chk("t3_fetch_pc", fetch_pc, 32'h1000);
        tick();
        halt = 1;
        wait_empty();

        // redirect in the same cycle as a response
        reset_dut();
        inst_ready = 1; halt = 0;
        tick(2);
        redirect_valid = 1; redirect_pc = 32'h2000;
        tick();
        redirect_valid = 0;
        exp_q = '{32'h2000};
        @(negedge clk);
        chk("t4_valid", 32'(inst_valid), 0);
        chk("t4_req", 32'(imem_req), 1);
        chk("t4_addr", imem_addr, 32'h2000);
        tick();
        halt = 1;
        wait_empty();

        // PC wraps past the top of the address space
        redirect_valid = 1; redirect_pc = 32'hFFFFFFFC; halt = 0;
        tick();
        redirect_valid = 0;
        exp_q = '{32'hFFFFFFFC, 32'h0};
        @(negedge clk);
        chk("t5_req", 32'(imem_req), 1);
        chk("t5_addr_top", imem_addr, 32'hFFFFFFFC);
        tick();
        @(negedge clk);
        chk("t5_addr_wrap", imem_addr, 0);
        chk("t5_fetch_pc", fetch_pc, 0);
        tick();
        halt = 1;
        wait_empty();

        // halt while a request is outstanding
        rv_en = 0; halt = 0;
        exp_q = '{32'h4};
        tick();
        halt = 1; rv_en = 1;
        @(negedge clk);
        chk("t6_req_wait", 32'(imem_req), 0);
        tick();
        g0 = grants;
        @(negedge clk);
        chk("t6_req_resp", 32'(imem_req), 0);
        wait_empty();
        tick(5);
        chk("t6_no_grants", grants - g0, 0);

        // reset mid-outstanding, then a late response
        rv_en = 0; halt = 0;
        tick();
        rst_b = 1; halt = 1;
        @(negedge clk);
        chk("t7_req_rst", 32'(imem_req), 0);
        tick();
        rst_b = 0; rv_en = 1;
        @(negedge clk);
        chk("t7_fetch_pc", fetch_pc, 0);
        tick();
        @(negedge clk);
        chk("t7_late_rvalid", 32'(imem_rvalid), 1);
        tick();
        @(negedge clk);
        chk("t7_no_push", 32'(inst_valid), 0);
        chk("t7_pc_reset", fetch_pc, 0);
        tick();
        halt = 0;
        exp_q = '{32'h0};
        tick();
        halt = 1;
        wait_empty();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
